// File: rtl/pbit_rng_scheduler.sv
// Shares one LFSR among N p-bit cells: reseed, warm up, then hand out one fresh
// random word per cycle to requesters in round-robin order, counting full sweeps.
module pbit_rng_scheduler #(
  parameter int N_PBITS = 8,
  parameter int STAGES  = 32,
  parameter int WARMUP  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [N_PBITS-1:0] req,
  input  logic [STAGES-1:0]  lfsr_in,
  output logic               lfsr_en,
  output logic               lfsr_rst,
  output logic [N_PBITS-1:0] grant,
  output logic [STAGES-1:0]  rand_out,
  output logic               rand_valid,
  output logic               running,
  output logic               sweep_done,
  output logic [15:0]        sweep_count
);

  // state    | meaning
  // S_IDLE   | LFSR parked, waiting for start
  // S_RESEED | one-cycle synchronous reseed of the LFSR
  // S_WARMUP | LFSR free-runs WARMUP cycles before its first use
  // S_RUN    | round-robin grants, LFSR steps once per grant
  typedef enum logic [1:0] {S_IDLE, S_RESEED, S_WARMUP, S_RUN} state_t;

  localparam int PW = $clog2(N_PBITS);
  localparam int WW = $clog2(WARMUP + 1);

  state_t              state_q, state_d;
  logic [WW-1:0]       warm_q, warm_d;
  logic [PW-1:0]       rr_q, rr_d, gcnt_q, gcnt_d;
  logic [15:0]         sweep_count_q, sweep_count_d;
  logic [N_PBITS-1:0]  grant_q, grant_d;
  logic [STAGES-1:0]   rand_out_q, rand_out_d;
  logic                rand_valid_q, rand_valid_d;
  logic                sweep_done_q, sweep_done_d;
  logic                running_q, running_d;
  logic                lfsr_rst_q, lfsr_rst_d;

  logic                found;
  logic [PW-1:0]       sel, cand;
  int                  idx;

  always_comb begin
    found = 1'b0;
    sel   = rr_q;
    cand  = '0;
    idx   = 0;
    for (int k = 1; k <= N_PBITS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_PBITS) idx = idx - N_PBITS;
      cand = PW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // lfsr_en is decoded in the grant cycle itself so the LFSR steps on the same
  // edge that captures its word; a registered enable would repeat words.
  always_comb begin
    state_d       = state_q;
    warm_d        = warm_q;
    rr_d          = rr_q;
    gcnt_d        = gcnt_q;
    sweep_count_d = sweep_count_q;
    grant_d       = '0;
    rand_out_d    = rand_out_q;
    rand_valid_d  = 1'b0;
    sweep_done_d  = 1'b0;
    lfsr_rst_d    = 1'b0;
    lfsr_en       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d       = S_RESEED;
          lfsr_rst_d    = 1'b1;
          sweep_count_d = '0;
          gcnt_d        = '0;
          rr_d          = PW'(N_PBITS - 1);
        end
      end
      S_RESEED: begin
        if (stop) state_d = S_IDLE;
        else begin
          state_d = S_WARMUP;
          warm_d  = WW'(WARMUP - 1);
        end
      end
      S_WARMUP: begin
        lfsr_en = 1'b1;
        if (stop)                state_d = S_IDLE;
        else if (warm_q == '0)   state_d = S_RUN;
        else                     warm_d  = warm_q - 1'b1;
      end
      S_RUN: begin
        if (stop) state_d = S_IDLE;
        else if (found) begin
          lfsr_en      = 1'b1;
          grant_d      = N_PBITS'(1) << sel;
          rand_out_d   = lfsr_in;
          rand_valid_d = 1'b1;
          rr_d         = sel;
          if (gcnt_q == PW'(N_PBITS - 1)) begin
            gcnt_d        = '0;
            sweep_done_d  = 1'b1;
            sweep_count_d = sweep_count_q + 16'd1;
          end else begin
            gcnt_d = gcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    running_d = (state_d == S_RUN);
  end

  // lfsr_rst resets high so the LFSR is reseeded across system reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      warm_q        <= '0;
      rr_q          <= PW'(N_PBITS - 1);
      gcnt_q        <= '0;
      sweep_count_q <= '0;
      grant_q       <= '0;
      rand_out_q    <= '0;
      rand_valid_q  <= 1'b0;
      sweep_done_q  <= 1'b0;
      running_q     <= 1'b0;
      lfsr_rst_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      warm_q        <= warm_d;
      rr_q          <= rr_d;
      gcnt_q        <= gcnt_d;
      sweep_count_q <= sweep_count_d;
      grant_q       <= grant_d;
      rand_out_q    <= rand_out_d;
      rand_valid_q  <= rand_valid_d;
      sweep_done_q  <= sweep_done_d;
      running_q     <= running_d;
      lfsr_rst_q    <= lfsr_rst_d;
    end
  end

  assign lfsr_rst    = lfsr_rst_q;
  assign grant       = grant_q;
  assign rand_out    = rand_out_q;
  assign rand_valid  = rand_valid_q;
  assign running     = running_q;
  assign sweep_done  = sweep_done_q;
  assign sweep_count = sweep_count_q;

endmodule

// File: tb/tb_pbit_rng_scheduler.sv
// Self-checking bench for pbit_rng_scheduler: cycle-age reference model plus
// directed scenarios and a randomized request phase.
module tb_pbit_rng_scheduler;
  localparam int N = 8;
  localparam int S = 32;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [N-1:0] req = '0;
  logic [S-1:0] lfsr_in;
  logic         lfsr_en, lfsr_rst, rand_valid, running, sweep_done;
  logic [N-1:0] grant;
  logic [S-1:0] rand_out;
  logic [15:0]  sweep_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pbit_rng_scheduler #(.N_PBITS(N), .STAGES(S), .WARMUP(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .req(req),
    .lfsr_in(lfsr_in), .lfsr_en(lfsr_en), .lfsr_rst(lfsr_rst),
    .grant(grant), .rand_out(rand_out), .rand_valid(rand_valid),
    .running(running), .sweep_done(sweep_done), .sweep_count(sweep_count)
  );

  // Environment LFSR (xorshift stand-in for the real LFSR instance).
  function automatic logic [S-1:0] xs(input logic [S-1:0] x);
    logic [S-1:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  logic [S-1:0] lf = '0;
  assign lfsr_in = lf;
  always @(posedge clk) begin
    if (lfsr_rst)     lf <= 32'hACE1_2468;
    else if (lfsr_en) lf <= xs(lf);
  end

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Reference model: age = cycles since start was accepted (-1 when idle).
  // Cycle 1 reseeds, cycles 2..W+1 warm up, W+2 onwards is the run phase.
  int           age = -1;
  int           m_rr = N - 1;
  int           m_gc = 0;
  logic [15:0]  m_sw = '0;
  logic [15:0]  sw_off = '0;
  logic [N-1:0] e_grant = '0;
  logic [S-1:0] e_rand = '0;
  logic         e_valid = 1'b0, e_done = 1'b0, e_lrst = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age = -1; m_rr = N - 1; m_gc = 0; m_sw = '0;
      e_grant = '0; e_rand = '0; e_valid = 1'b0; e_done = 1'b0; e_lrst = 1'b1;
    end else begin
      e_grant = '0; e_valid = 1'b0; e_done = 1'b0; e_lrst = 1'b0;
      if (age < 0) begin
        if (start && !stop) begin
          age = 1; m_gc = 0; m_sw = '0; m_rr = N - 1; e_lrst = 1'b1;
        end
      end else if (stop) begin
        age = -1;
      end else begin
        if (age >= W + 2 && req != '0) begin
          int win;
          win = -1;
          for (int k = 1; k <= N; k++)
            if (win < 0 && req[(m_rr + k) % N]) win = (m_rr + k) % N;
          e_grant[win] = 1'b1;
          e_rand  = lfsr_in;
          e_valid = 1'b1;
          m_rr    = win;
          m_gc    = m_gc + 1;
          if (m_gc == N) begin
            m_gc = 0; m_sw = m_sw + 16'd1; e_done = 1'b1;
          end
        end
        if (age < 1000) age = age + 1;
      end
    end
  end

  always @(negedge clk) begin : checker_p
    logic        e_en;
    logic [15:0] exp_sw;
    e_en   = (age >= 2 && age <= W + 1) || (age >= W + 2 && req != '0 && !stop);
    exp_sw = m_sw + sw_off;
    cmp("grant", grant, e_grant);
    cmp("rand_valid", rand_valid, e_valid);
    if (e_valid) cmp("rand_out", rand_out, e_rand);
    cmp("sweep_done", sweep_done, e_done);
    cmp("sweep_count", sweep_count, exp_sw);
    cmp("running", running, age >= W + 2);
    cmp("lfsr_rst", lfsr_rst, e_lrst);
    cmp("lfsr_en", lfsr_en, e_en);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int cycles, output int ndone);
    ndone = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (sweep_done) ndone++;
      req = req & ~grant;
    end
  endtask

  task automatic to_run();
    start = 1'b1; tick(); start = 1'b0;
    repeat (W + 1) tick();
  endtask

  int n_rst, n_en, run_cyc, ngr, gi, first_c, ndone, done_pos, dups, n_run;
  logic [S-1:0] words [8];
  logic got;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_lfsr_rst", lfsr_rst, 1);
    cmp("rst_grant", grant, 0);
    cmp("rst_rand_out", rand_out, 0);
    cmp("rst_sweep_count", sweep_count, 0);
    cmp("rst_lfsr_en", lfsr_en, 0);
    cmp("rst_running", running, 0);
    @(negedge clk) rst = 1'b0;
    tick();
    cmp("lfsr_rst_release", lfsr_rst, 0);

    // Start with no requests: reseed, warm-up length, run entry cycle.
    start = 1'b1; tick(); start = 1'b0;
    n_rst = 0; n_en = 0; run_cyc = -1; ngr = 0;
    for (int c = 1; c <= 10; c++) begin
      if (lfsr_rst) n_rst++;
      if (lfsr_en) n_en++;
      if (running && run_cyc < 0) run_cyc = c;
      if (grant != '0) ngr++;
      tick();
    end
    cmp("t1_rst_pulses", n_rst, 1);
    cmp("t1_en_cycles", n_en, 4);
    cmp("t1_run_cycle", run_cyc, 6);
    cmp("t1_no_grants", ngr, 0);

    // All eight request, each drops once granted.
    req = 8'hFF; gi = 0; first_c = -1; ndone = 0; done_pos = -1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (grant != '0) begin
        if (first_c < 0) first_c = c;
        cmp("t2_order", oh_idx(grant), gi);
        cmp("t2_consecutive", c - first_c, gi);
        if (gi < 8) words[gi] = rand_out;
        if (sweep_done) begin ndone++; done_pos = gi; end
        gi++;
      end
      req = req & ~grant;
    end
    dups = 0;
    for (int i = 0; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (words[i] == words[j]) dups++;
    cmp("t2_grants", gi, 8);
    cmp("t2_distinct", dups, 0);
    cmp("t2_done_count", ndone, 1);
    cmp("t2_done_pos", done_pos, 7);
    cmp("t2_sweep_count", sweep_count, 1);

    // Two requesters held continuously alternate.
    req = 8'b1000_0001; gi = 0; ndone = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (grant != '0) begin
        cmp("t3_alternate", oh_idx(grant), (gi % 2 == 0) ? 0 : 7);
        if (sweep_done) begin ndone++; cmp("t3_done_pos", gi % 8, 7); end
        gi++;
        if (gi == 16) req = '0;
      end
    end
    cmp("t3_grants", gi, 16);
    cmp("t3_done_count", ndone, 2);
    cmp("t3_sweep_count", sweep_count, 3);

    // stop wins over start in IDLE; stop aborts warm-up.
    stop = 1'b1; tick(); stop = 1'b0;
    cmp("t4_stopped", running, 0);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    n_rst = 0; n_run = 0;
    for (int c = 0; c < 5; c++) begin
      if (lfsr_rst) n_rst++;
      if (running) n_run++;
      tick();
    end
    cmp("t4_no_reseed", n_rst, 0);
    cmp("t4_no_run", n_run, 0);
    start = 1'b1; tick(); start = 1'b0;
    cmp("t4_reseed", lfsr_rst, 1);
    tick();
    cmp("t4_warm_en", lfsr_en, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    cmp("t4_en_off", lfsr_en, 0);
    n_run = 0;
    for (int c = 0; c < 6; c++) begin
      if (running || lfsr_en) n_run++;
      tick();
    end
    cmp("t4_idle_after_stop", n_run, 0);

    // Async reset in the middle of a grant.
    to_run();
    req = 8'hFF; drain(12, ndone);
    cmp("t5_first_sweep", sweep_count, 1);
    req = 8'hFF; got = 1'b0;
    for (int c = 0; c < 10; c++) if (!got) begin
      tick();
      if (grant != '0) got = 1'b1;
    end
    cmp("t5_grant_seen", got, 1);
    if (got) begin
      #1 rst = 1'b1;
      #1;
      cmp("t5_grant_clr", grant, 0);
      cmp("t5_valid_clr", rand_valid, 0);
      cmp("t5_count_clr", sweep_count, 0);
      cmp("t5_lfsr_rst", lfsr_rst, 1);
    end
    @(negedge clk); req = '0; rst = 1'b0;
    tick();
    to_run();
    req = 8'hFF; got = 1'b0;
    for (int c = 0; c < 10; c++) if (!got) begin
      tick();
      if (grant != '0) begin
        got = 1'b1;
        cmp("t5_first_after_rst", oh_idx(grant), 0);
      end
      req = req & ~grant;
    end
    cmp("t5_grant_after_rst", got, 1);
    drain(12, ndone);
    cmp("t5_sweep_after_rst", sweep_count, 1);

    // Sweep counter wrap.
    force dut.sweep_count_q = 16'hFFFF;
    sw_off = 16'hFFFF - m_sw;
    #1 release dut.sweep_count_q;
    req = 8'hFF; drain(12, ndone);
    cmp("t6_done_once", ndone, 1);
    cmp("t6_wrapped", sweep_count, 0);

    // Randomized requests with occasional stop/start, checked by the model.
    stop = 1'b1; tick(); stop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    sw_off = '0;
    for (int c = 0; c < 600; c++) begin
      tick();
      req   = (req & ~grant) | (N'($urandom) & N'($urandom));
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 79) == 0);
    end
    start = 1'b0; stop = 1'b0; req = '0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
